// File: rtl/dsp_arbiter_if.sv
// Request, response and shared-datapath signals between dsp_arbiter and its two requesters.
interface dsp_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic [WIDTH-1:0] dsp_a;
  logic [WIDTH-1:0] dsp_b;
  logic [WIDTH-1:0] dsp_add;
  logic [WIDTH-1:0] dsp_sub;
  logic             dsp_carry;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
           req1_valid, req1_op, req1_a, req1_b,
           rsp0_ready, rsp1_ready, dsp_add, dsp_sub, dsp_carry,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_data, rsp_carry, dsp_a, dsp_b, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
           req1_valid, req1_op, req1_a, req1_b,
           rsp0_ready, rsp1_ready, dsp_add, dsp_sub, dsp_carry,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_data, rsp_carry, dsp_a, dsp_b, busy
  );
endinterface

// File: rtl/dsp_arbiter.sv
// Two-requester arbiter sharing one external add/sub datapath; one operation in flight at a time.
module dsp_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             id_q;
  logic             op_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       cnt_q;

  logic grant_d;
  logic accept_d;
  logic rspDone_d;

  // Priority pointer only matters when both requesters are valid.
  always_comb begin
    grant_d = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_d = ptr_q;
  end

  assign accept_d  = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign rspDone_d = (state_q == RESP) && (id_q ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.req0_ready = accept_d && !grant_d;
  assign bus.req1_ready = accept_d && grant_d;
  assign bus.rsp0_valid = (state_q == RESP) && !id_q;
  assign bus.rsp1_valid = (state_q == RESP) && id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.dsp_a      = a_q;
  assign bus.dsp_b      = b_q;
  assign bus.busy       = (state_q != IDLE);

  // The counter holds LATENCY in the first EXEC cycle and reaches zero in the cycle the
  // datapath result has been valid for a full cycle, LATENCY cycles after operands settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            id_q    <= grant_d;
            op_q    <= grant_d ? bus.req1_op : bus.req0_op;
            a_q     <= grant_d ? bus.req1_a : bus.req0_a;
            b_q     <= grant_d ? bus.req1_b : bus.req0_b;
            cnt_q   <= 3'(LATENCY);
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 3'd0) begin
            data_q  <= op_q ? bus.dsp_sub : bus.dsp_add;
            carry_q <= op_q & bus.dsp_carry;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (rspDone_d) begin
            ptr_q   <= ~id_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_arbiter.sv
// Bench for dsp_arbiter: directed vector table, multi-cycle corner sequences and a randomized run.
module tb_dsp_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dsp_arbiter_if #(.WIDTH(32)) bus1();
  dsp_arbiter_if #(.WIDTH(32)) bus3();

  dsp_arbiter #(.WIDTH(32), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dsp_arbiter #(.WIDTH(32), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined datapath models: result valid LATENCY cycles after the operands change.
  logic [31:0] p1a, p1b;
  logic [31:0] p3a [3];
  logic [31:0] p3b [3];
  always @(posedge clk) begin
    p1a <= bus1.dsp_a;
    p1b <= bus1.dsp_b;
    p3a[0] <= bus3.dsp_a;
    p3b[0] <= bus3.dsp_b;
    p3a[1] <= p3a[0];
    p3b[1] <= p3b[0];
    p3a[2] <= p3a[1];
    p3b[2] <= p3b[1];
  end
  assign bus1.dsp_add   = p1a + p1b;
  assign bus1.dsp_sub   = p1a - p1b;
  assign bus1.dsp_carry = (p1a < p1b);
  assign bus3.dsp_add   = p3a[2] + p3b[2];
  assign bus3.dsp_sub   = p3a[2] - p3b[2];
  assign bus3.dsp_carry = (p3a[2] < p3b[2]);

  typedef struct {
    bit          port;
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expData;
    bit          expCarry;
    int          rdyDelay;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] gotData;
  logic        gotCarry;
  logic        execCarry;
  int          gotLat;
  int          waitCyc;
  bit          stable;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setReq(input bit port, input bit valid, input bit op, input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      bus1.req1_valid = valid; bus1.req1_op = op; bus1.req1_a = a; bus1.req1_b = b;
    end else begin
      bus1.req0_valid = valid; bus1.req0_op = op; bus1.req0_a = a; bus1.req0_b = b;
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    setReq(0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0);
    bus1.rsp0_ready = 1'b0;
    bus1.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction on the LATENCY=1 instance with optional response backpressure.
  task automatic applyStimulus(input bit port, input bit op, input logic [31:0] a, input logic [31:0] b,
                               input int rdyDelay, output logic [31:0] data, output logic carry,
                               output logic exCarry, output int lat, output int wt, output bit stab);
    @(negedge clk);
    setReq(port, 1, op, a, b);
    #1;
    wt = 0;
    while (!(port ? bus1.req1_ready : bus1.req0_ready) && wt < 20) begin
      @(negedge clk); #1; wt++;
    end
    @(posedge clk);
    @(negedge clk);
    setReq(port, 0, 0, 0, 0);
    #1;
    lat = 0;
    exCarry = bus1.dsp_carry;
    while (!(port ? bus1.rsp1_valid : bus1.rsp0_valid) && lat < 20) begin
      exCarry = bus1.dsp_carry;
      @(negedge clk); #1; lat++;
    end
    data  = bus1.rsp_data;
    carry = bus1.rsp_carry;
    stab  = 1'b1;
    repeat (rdyDelay) begin
      @(negedge clk); #1;
      if (bus1.rsp_data !== data || bus1.rsp_carry !== carry || !(port ? bus1.rsp1_valid : bus1.rsp0_valid))
        stab = 1'b0;
    end
    @(negedge clk);
    if (port) bus1.rsp1_ready = 1'b1; else bus1.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.rsp0_ready = 1'b0;
    bus1.rsp1_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, wanted $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          r0, r1, v0, v1, g, inFlight, expId, expRv, modelPtr, expCarryM;
    logic [31:0] expDataM, d, a3, b3;
    int          edges, nGrant, both, early, unstable, seen, moved;
    bit          grants [4];

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    setReq(0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0);
    bus1.rsp0_ready = 1'b0;
    bus1.rsp1_ready = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req0_op = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0;
    bus3.req1_valid = 1'b0; bus3.req1_op = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0;
    bus3.rsp0_ready = 1'b0;
    bus3.rsp1_ready = 1'b0;

    vecs[0] = '{0, 0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 0, 0};
    vecs[1] = '{1, 1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0};
    vecs[2] = '{0, 1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 0, 2};
    vecs[3] = '{1, 0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 0};
    vecs[4] = '{0, 1, 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 1, 3};
    vecs[5] = '{1, 0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {bus1.busy, bus3.busy}, 0);
    checkOutput("rst_rsp_valid", {bus1.rsp0_valid, bus1.rsp1_valid, bus3.rsp0_valid, bus3.rsp1_valid}, 0);
    checkOutput("rst_rsp_data", bus1.rsp_data, 0);
    checkOutput("rst_rsp_carry", bus1.rsp_carry, 0);
    checkOutput("rst_dsp_ab", {bus1.dsp_a, bus1.dsp_b}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdyDelay,
                    gotData, gotCarry, execCarry, gotLat, waitCyc, stable);
      checkOutput($sformatf("vec%0d_data", i), gotData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_carry", i), gotCarry, vecs[i].expCarry);
      checkOutput($sformatf("vec%0d_latency", i), gotLat, 2);
      checkOutput($sformatf("vec%0d_wait", i), waitCyc, 0);
      checkOutput($sformatf("vec%0d_stable", i), stable, 1);
      if (vecs[i].op) checkOutput($sformatf("vec%0d_exec_carry", i), gotCarry, execCarry);
    end

    // Both requesters valid back to back: alternating grants, never two readies.
    resetDut();
    @(negedge clk);
    setReq(0, 1, 0, 32'd1, 32'd2);
    setReq(1, 1, 1, 32'd9, 32'd4);
    bus1.rsp0_ready = 1'b1;
    bus1.rsp1_ready = 1'b1;
    nGrant = 0;
    both = 0;
    for (int n = 0; n < 24; n++) begin
      #1;
      if (bus1.req0_ready && bus1.req1_ready) both++;
      if ((bus1.req0_ready || bus1.req1_ready) && nGrant < 4) begin
        grants[nGrant] = bus1.req1_ready;
        nGrant++;
      end
      @(negedge clk);
    end
    checkOutput("sim_two_ready", both, 0);
    checkOutput("sim_grant_count", nGrant, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("sim_grant%0d", i), grants[i], i % 2);
    setReq(0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    bus1.rsp0_ready = 1'b0;
    bus1.rsp1_ready = 1'b0;

    // Response backpressure holds req1 off until req0's handshake completes.
    @(negedge clk);
    setReq(0, 1, 0, 32'd100, 32'd23);
    #1;
    for (int n = 0; n < 20 && !bus1.req0_ready; n++) begin @(negedge clk); #1; end
    checkOutput("bp_accept0", bus1.req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    setReq(0, 0, 0, 0, 0);
    setReq(1, 1, 0, 32'd1, 32'd1);
    #1;
    early = 0;
    for (int n = 0; n < 20 && !bus1.rsp0_valid; n++) begin
      if (bus1.req1_ready) early++;
      @(negedge clk); #1;
    end
    checkOutput("bp_rsp0_valid", bus1.rsp0_valid, 1);
    d = bus1.rsp_data;
    checkOutput("bp_data", d, 32'd123);
    unstable = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (bus1.rsp_data !== d || !bus1.rsp0_valid) unstable++;
      if (bus1.req1_ready) early++;
    end
    checkOutput("bp_stable", unstable, 0);
    @(negedge clk);
    bus1.rsp0_ready = 1'b1;
    #1;
    if (bus1.req1_ready) early++;
    checkOutput("bp_req1_held", early, 0);
    @(posedge clk);
    @(negedge clk);
    bus1.rsp0_ready = 1'b0;
    #1;
    checkOutput("bp_req1_next", bus1.req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    setReq(1, 0, 0, 0, 0);
    #1;
    for (int n = 0; n < 20 && !bus1.rsp1_valid; n++) begin @(negedge clk); #1; end
    checkOutput("bp_data1", bus1.rsp_data, 32'd2);
    bus1.rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.rsp1_ready = 1'b0;

    // Reset during EXEC abandons the operation and clears the pointer.
    applyStimulus(0, 0, 32'd7, 32'd7, 0, gotData, gotCarry, execCarry, gotLat, waitCyc, stable);
    @(negedge clk);
    setReq(0, 1, 0, 32'd9, 32'd9);
    #1;
    checkOutput("rx_accept", bus1.req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    setReq(0, 0, 0, 0, 0);
    #1;
    checkOutput("rx_in_exec", bus1.busy, 1);
    rst_n = 1'b0;
    bus1.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rx_busy", bus1.busy, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus1.rsp0_valid || bus1.rsp1_valid || bus1.busy) seen++;
    end
    checkOutput("rx_no_response", seen, 0);
    bus1.rsp0_ready = 1'b0;
    @(negedge clk);
    setReq(0, 1, 0, 32'd1, 32'd1);
    setReq(1, 1, 0, 32'd2, 32'd2);
    #1;
    checkOutput("rx_ptr_zero", {bus1.req0_ready, bus1.req1_ready}, 2'b10);
    setReq(0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0);

    // A request held through reset is accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b0;
    setReq(1, 1, 0, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", bus1.req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    setReq(1, 0, 0, 0, 0);
    #1;
    checkOutput("post_rst_busy", bus1.busy, 1);
    bus1.rsp1_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus1.rsp1_ready = 1'b0;

    // Randomized run against a transaction-level model of grant, result and timing.
    resetDut();
    modelPtr = 1'b0;
    inFlight = 1'b0;
    expId = 1'b0;
    expDataM = '0;
    expCarryM = 1'b0;
    edges = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      setReq(0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom, $urandom);
      setReq(1, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus1.req0_b = bus1.req0_a;
      end
      bus1.rsp0_ready = 1'($urandom_range(0, 1));
      bus1.rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      r0 = bus1.req0_ready;
      r1 = bus1.req1_ready;
      v0 = bus1.req0_valid;
      v1 = bus1.req1_valid;
      checkOutput("rnd_one_ready", r0 & r1, 0);
      if (inFlight) begin
        edges++;
        expRv = (edges >= 2);
        checkOutput("rnd_no_grant", {r0, r1}, 0);
        checkOutput("rnd_busy", bus1.busy, 1);
        checkOutput("rnd_rsp_valid", {bus1.rsp0_valid, bus1.rsp1_valid}, {expRv && !expId, expRv && expId});
        if (expRv) begin
          checkOutput("rnd_data", bus1.rsp_data, expDataM);
          checkOutput("rnd_carry", bus1.rsp_carry, expCarryM);
          if (expId ? bus1.rsp1_ready : bus1.rsp0_ready) begin
            inFlight = 1'b0;
            modelPtr = ~expId;
          end
        end
      end else begin
        checkOutput("rnd_idle", {bus1.busy, bus1.rsp0_valid, bus1.rsp1_valid}, 0);
        g = (v0 && v1) ? modelPtr : v1;
        checkOutput("rnd_ready", {r0, r1}, {(v0 || v1) && !g, (v0 || v1) && g});
        if (v0 || v1) begin
          inFlight = 1'b1;
          edges = -1;
          expId = g;
          a3 = g ? bus1.req1_a : bus1.req0_a;
          b3 = g ? bus1.req1_b : bus1.req0_b;
          if (g ? bus1.req1_op : bus1.req0_op) begin
            expDataM = a3 - b3;
            expCarryM = (a3 < b3);
          end else begin
            expDataM = a3 + b3;
            expCarryM = 1'b0;
          end
        end
      end
    end
    resetDut();

    // LATENCY=3 instance: four edges from accept to response, operands held throughout.
    @(negedge clk);
    bus3.req1_valid = 1'b1;
    bus3.req1_op = 1'b1;
    bus3.req1_a = 32'h0000_1000;
    bus3.req1_b = 32'h0000_0001;
    #1;
    checkOutput("l3_ready", bus3.req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus3.req1_valid = 1'b0;
    bus3.req1_a = '0;
    bus3.req1_b = '0;
    #1;
    a3 = bus3.dsp_a;
    b3 = bus3.dsp_b;
    checkOutput("l3_dsp_ab", {a3, b3}, {32'h0000_1000, 32'h0000_0001});
    moved = 0;
    gotLat = 0;
    while (!bus3.rsp1_valid && gotLat < 20) begin
      @(negedge clk); #1; gotLat++;
      if (bus3.dsp_a !== a3 || bus3.dsp_b !== b3) moved++;
    end
    checkOutput("l3_latency", gotLat, 4);
    checkOutput("l3_data", bus3.rsp_data, 32'h0000_0FFF);
    checkOutput("l3_carry", bus3.rsp_carry, 0);
    repeat (2) begin
      @(negedge clk); #1;
      if (bus3.dsp_a !== a3 || bus3.dsp_b !== b3) moved++;
    end
    bus3.rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.rsp1_ready = 1'b0;
    checkOutput("l3_dsp_hold", moved, 0);
    checkOutput("l3_done", {bus3.busy, bus3.rsp1_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
